// File: rtl/light_ctrl_pkg.sv
// rtl/light_ctrl_pkg.sv - shared state encoding, colour range and helpers for the light show controller
package light_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WHITE  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  localparam logic [2:0]  COLOUR_FIRST = 3'd1;
  localparam logic [2:0]  COLOUR_LAST  = 3'd6;
  localparam logic [23:0] WHITE_RGB    = 24'hFFFFFF;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c >= COLOUR_LAST) ? COLOUR_FIRST : c + 3'd1;
  endfunction

  // Mode button cycles WHITE -> MANUAL -> AUTO -> WHITE; the unused code falls back to WHITE
  function automatic state_t next_state(input state_t s);
    case (s)
      ST_WHITE:  return ST_MANUAL;
      ST_MANUAL: return ST_AUTO;
      default:   return ST_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchroniser, stable-count debouncer and rising-edge event
module button_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      // Count consecutive disagreeing samples; any agreeing sample restarts the count
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/light_show_controller.sv
// rtl/light_show_controller.sv - mode FSM, auto-step timer, step pulse and colour mirror for lights_selector
module light_show_controller
  import light_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int PER_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_btn,
  input  logic             step_btn,
  input  logic [PER_W-1:0] period,
  output logic             sel,
  output logic             button,
  output logic [2:0]       colour_idx,
  output logic [1:0]       mode
);

  state_t           state;
  logic [PER_W-1:0] timer;
  logic             mode_ev;
  logic             step_ev;
  logic             terminal;

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (mode_btn),
    .rise (mode_ev)
  );

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (step_btn),
    .rise (step_ev)
  );

  // timer >= period-1 without underflow; also catches a period shortened below the running count
  assign terminal = ({1'b0, timer} + {{PER_W{1'b0}}, 1'b1}) >= {1'b0, period};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WHITE;
      sel        <= 1'b0;
      button     <= 1'b0;
      colour_idx <= COLOUR_FIRST;
      timer      <= '0;
    end else begin
      button <= 1'b0;
      if (mode_ev) begin
        // A mode change takes priority over any step or timer pulse in the same cycle
        state <= next_state(state);
        sel   <= (next_state(state) != ST_WHITE);
        timer <= '0;
      end else begin
        case (state)
          ST_MANUAL: begin
            if (step_ev) begin
              button     <= 1'b1;
              colour_idx <= next_colour(colour_idx);
            end
          end
          ST_AUTO: begin
            if (period == '0) begin
              timer <= '0;
            end else if (terminal) begin
              button     <= 1'b1;
              colour_idx <= next_colour(colour_idx);
              timer      <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_light_show_controller.sv
// tb/tb_light_show_controller.sv - randomized directed bench for light_show_controller with timing-rule reference model
module tb_light_show_controller;
  import light_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] period = 8'd0;
  logic       sel;
  logic       button;
  logic [2:0] colour_idx;
  logic [1:0] mode;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int viol = 0;
  int exp_colour = 1;
  int pq[$];
  int cq[$];
  int mq[$];
  int eq[$];
  logic       prev_button = 1'b0;
  logic [1:0] prev_mode = 2'd0;

  light_show_controller #(.DEB_CYCLES(DEB), .PER_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn   (mode_btn),
    .step_btn   (step_btn),
    .period     (period),
    .sel        (sel),
    .button     (button),
    .colour_idx (colour_idx),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge number of every pulse / mode change and flags invariant violations
  always @(negedge clk) begin
    if (button === 1'b1) begin
      pq.push_back(cyc);
      cq.push_back(32'(colour_idx));
    end
    if ((button === 1'b1 && sel !== 1'b1) ||
        (button === 1'b1 && prev_button === 1'b1 && mode === 2'd1))
      viol <= viol + 1;
    if (mode !== prev_mode) mq.push_back(cyc);
    prev_button <= button;
    prev_mode   <= mode;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input bit m, input bit s, input int hold, output int k);
    @(negedge clk);
    if (m) mode_btn = 1'b1;
    if (s) step_btn = 1'b1;
    k = cyc + 1;
    repeat (hold) @(negedge clk);
    mode_btn = 1'b0;
    step_btn = 1'b0;
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Compares recorded pulse edges against eq and the colour at each pulse against the wrap rule
  task automatic check_pulses(input string tag);
    chk({tag, "_count"}, pq.size(), eq.size());
    for (int i = 0; i < eq.size(); i++) begin
      exp_colour = (exp_colour % 6) + 1;
      if (i < pq.size()) begin
        chk({tag, "_edge"}, pq[i], eq[i]);
        chk({tag, "_colour"}, cq[i], exp_colour);
      end
    end
    pq.delete();
    cq.delete();
    eq.delete();
  endtask

  initial begin
    int k;
    int e;
    int f;
    int p;
    int h;

    wait_cyc(2);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_button", 32'(button), 0);
    chk("rst_colour", 32'(colour_idx), 1);
    chk("rst_mode", 32'(mode), 0);
    rst = 1'b0;
    exp_colour = 1;
    pq.delete(); cq.delete(); mq.delete();

    repeat (2) begin
      press(0, 1, $urandom_range(5, 10), k);
      wait_cyc(12);
    end
    check_pulses("white_steps");
    chk("white_colour", 32'(colour_idx), 1);

    press(1, 0, $urandom_range(5, 10), k);
    wait_cyc(12);
    chk("to_manual_edge", first_of(mq), k + LAT);
    chk("to_manual_mode", 32'(mode), 1);
    chk("to_manual_sel", 32'(sel), 1);
    mq.delete();

    press(0, 1, $urandom_range(1, DEB - 1), k);
    wait_cyc(15);
    check_pulses("glitch");

    for (int i = 0; i < 7; i++) begin
      h = (i == 0) ? 10 : $urandom_range(DEB, 12);
      press(0, 1, h, k);
      eq.push_back(k + LAT);
      wait_cyc($urandom_range(8, 14));
    end
    check_pulses("manual");
    chk("manual_colour", 32'(colour_idx), exp_colour);

    p = $urandom_range(1, 7);
    period = 8'(p);
    press(1, 0, 8, k);
    e = k + LAT;
    eq.push_back(e + p);
    eq.push_back(e + 2 * p);
    eq.push_back(e + 3 * p);
    wait_until(e + 3 * p);
    period = 8'd0;
    wait_cyc(20);
    chk("to_auto_edge", first_of(mq), e);
    chk("to_auto_mode", 32'(mode), 2);
    chk("to_auto_sel", 32'(sel), 1);
    check_pulses("auto_period");
    mq.delete();

    period = 8'd5;
    f = cyc + 1;
    wait_until(f + 2);
    period = 8'd2;
    eq.push_back(f + 3);
    eq.push_back(f + 5);
    eq.push_back(f + 7);
    wait_until(f + 7);
    period = 8'd0;
    wait_cyc(10);
    check_pulses("reprogram");

    press(1, 0, $urandom_range(5, 10), k);
    wait_cyc(12);
    chk("to_white_edge", first_of(mq), k + LAT);
    chk("to_white_mode", 32'(mode), 0);
    chk("to_white_sel", 32'(sel), 0);
    chk("white_keeps_colour", 32'(colour_idx), exp_colour);
    mq.delete();

    press(1, 0, $urandom_range(5, 10), k);
    wait_cyc(12);
    chk("resume_mode", 32'(mode), 1);
    chk("resume_colour", 32'(colour_idx), exp_colour);
    mq.delete();

    press(1, 1, 8, k);
    wait_cyc(12);
    chk("simul_edge", first_of(mq), k + LAT);
    chk("simul_mode", 32'(mode), 2);
    check_pulses("simul");
    chk("simul_colour", 32'(colour_idx), exp_colour);

    period = 8'd3;
    wait_cyc($urandom_range(5, 12));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_button", 32'(button), 0);
    chk("midrst_colour", 32'(colour_idx), 1);
    chk("midrst_mode", 32'(mode), 0);
    rst = 1'b0;
    pq.delete(); cq.delete();
    exp_colour = 1;
    wait_cyc(15);
    check_pulses("after_rst");
    chk("after_rst_mode", 32'(mode), 0);

    chk("invariants", viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
